// File: rtl/noc_port_arbiter_if.sv
// Handshake and data bundle between the output-port arbiter and its environment.
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters and the downstream link.
interface noc_port_arbiter_if;
  logic         enable;
  logic [4:0]   req;
  logic [159:0] flit_in;
  logic         out_ready;
  logic [4:0]   grant;
  logic [2:0]   gate;
  logic [31:0]  flit_out;
  logic         flit_valid;
  logic [3:0]   owner;
  logic         busy;
  logic         timeout;

  modport master (
    output enable, req, flit_in, out_ready,
    input  grant, gate, flit_out, flit_valid, owner, busy, timeout
  );

  modport slave (
    input  enable, req, flit_in, out_ready,
    output grant, gate, flit_out, flit_valid, owner, busy, timeout
  );
endinterface

// File: rtl/noc_port_arbiter.sv
// Output-port arbiter for one mesh router port.
// Five requesters share one 32-bit output link. Arbitration is round-robin, and
// the winner keeps the link from its head flit to its tail flit. A watchdog
// takes the link back from a packet that stalls too long.
//
// state | meaning
// IDLE  | no owner; picks the next requester in rotating order
// LOCK  | link owned by requester 'gate'; forwards its flits until tail or timeout
module noc_port_arbiter #(
  parameter int          NREQ    = 5,
  parameter logic [9:0]  TIMEOUT = 10'd50,
  parameter logic [3:0]  ADDR    = 4'b0000
) (
  input  logic               clk,
  input  logic               reset,
  noc_port_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [2:0] GATE_IDLE  = 3'b111;
  localparam logic [3:0] OWNER_IDLE = 4'hF;

  state_t      state_q, state_d;
  logic [4:0]  grant_q, grant_d;
  logic [2:0]  gate_q, gate_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [9:0]  wdog_q, wdog_d;
  logic [31:0] flit_out_q, flit_out_d;
  logic        flit_valid_q, flit_valid_d;
  logic [3:0]  owner_q, owner_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;

  logic [7:0]  req_ext;
  logic [31:0] flit_arr [8];
  logic        pick_valid;
  logic [2:0]  pick_idx;
  logic        xfer;
  logic [31:0] cur_flit;
  logic        is_last;

  // Index that lies 'step' places after 'base' in the circular order 0..NREQ-1.
  function automatic logic [2:0] rr_index(input logic [2:0] base, input int step);
    int s;
    s = (int'(base) + step) % NREQ;
    return 3'(s);
  endfunction

  // Unpack the flit bus into an array. The array is padded to 8 entries so that
  // the idle gate value 7 selects zero instead of an out-of-range slice.
  always_comb begin
    req_ext = {3'b000, bus.req};
    for (int i = 0; i < 8; i++) flit_arr[i] = '0;
    for (int i = 0; i < NREQ; i++) flit_arr[i] = bus.flit_in[32*i +: 32];
  end

  // Rotating search. The loop runs from the farthest place to the nearest, so the
  // requester closest after rr_ptr is the last assignment and wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 3'd0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_ext[rr_index(rr_ptr_q, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_index(rr_ptr_q, k);
      end
    end
  end

  // A transfer needs the owner's request and a ready link. A tail or single-flit
  // packet (bit 31 set) ends the packet.
  always_comb begin
    cur_flit = flit_arr[gate_q];
    xfer     = bus.enable && req_ext[gate_q] && bus.out_ready;
    is_last  = cur_flit[31];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gate_d       = gate_q;
    rr_ptr_d     = rr_ptr_q;
    wdog_d       = wdog_q;
    flit_out_d   = flit_out_q;
    flit_valid_d = 1'b0;
    owner_d      = owner_q;
    busy_d       = busy_q;
    timeout_d    = 1'b0;

    if (bus.enable) begin
      unique case (state_q)
        IDLE: begin
          wdog_d = '0;
          if (pick_valid) begin
            state_d = LOCK;
            grant_d = 5'b00001 << pick_idx;
            gate_d  = pick_idx;
            busy_d  = 1'b1;
            owner_d = ADDR;
          end
        end
        LOCK: begin
          if (xfer) begin
            flit_out_d   = cur_flit;
            flit_valid_d = 1'b1;
            wdog_d       = '0;
          end else if (wdog_q != 10'h3FF) begin
            wdog_d = wdog_q + 10'd1;
          end
          // The owner index becomes rr_ptr, so the search starts after the owner.
          if ((xfer && is_last) || (!xfer && wdog_q == TIMEOUT - 10'd1)) begin
            state_d   = IDLE;
            grant_d   = '0;
            gate_d    = GATE_IDLE;
            busy_d    = 1'b0;
            owner_d   = OWNER_IDLE;
            rr_ptr_d  = gate_q;
            wdog_d    = '0;
            timeout_d = !xfer;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers. rr_ptr resets to 4, so requester 0 has first priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gate_q       <= GATE_IDLE;
      rr_ptr_q     <= 3'd4;
      wdog_q       <= '0;
      flit_out_q   <= '0;
      flit_valid_q <= 1'b0;
      owner_q      <= OWNER_IDLE;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gate_q       <= gate_d;
      rr_ptr_q     <= rr_ptr_d;
      wdog_q       <= wdog_d;
      flit_out_q   <= flit_out_d;
      flit_valid_q <= flit_valid_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.gate       = gate_q;
  assign bus.flit_out   = flit_out_q;
  assign bus.flit_valid = flit_valid_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Bench for the output-port arbiter. It runs a directed vector table, then
// hand-written watchdog and reset sequences, then random traffic that is
// compared against a packet-level reference model.
module tb_noc_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  noc_port_arbiter_if bus();
  noc_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  rq;
    logic        rdy;
    logic [1:0]  ty;
    logic [4:0]  g;
    logic [2:0]  gt;
    logic        fv;
    logic [31:0] fo;
    logic        b;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every requester presents a flit of type 'ty' whose low nibble is its own index.
  function automatic logic [159:0] flits_of(input logic [1:0] ty);
    logic [159:0] f;
    for (int i = 0; i < 5; i++) f[32*i +: 32] = {ty, 26'h0, 4'(i)};
    return f;
  endfunction

  function automatic vec_t mk(input logic en, input logic [4:0] rq, input logic rdy,
                              input logic [1:0] ty, input logic [4:0] g, input logic [2:0] gt,
                              input logic fv, input logic [31:0] fo, input logic b);
    vec_t v;
    v.en = en; v.rq = rq; v.rdy = rdy; v.ty = ty; v.g = g; v.gt = gt; v.fv = fv; v.fo = fo; v.b = b;
    return v;
  endfunction

  // Packet-level reference model
  bit          m_lock;
  int          m_own, m_ptr, m_stall, m_c;
  logic [31:0] m_flit;
  bit          m_fv, m_to;

  task automatic model_reset();
    m_lock = 0; m_own = 0; m_ptr = 4; m_stall = 0; m_flit = '0; m_fv = 0; m_to = 0;
  endtask

  task automatic model_step(input logic en, input logic [4:0] rq, input logic rdy,
                            input logic [159:0] fl);
    m_fv = 0;
    m_to = 0;
    if (en) begin
      if (!m_lock) begin
        m_stall = 0;
        for (int k = 1; k <= 5; k++) begin
          m_c = (m_ptr + k) % 5;
          if (rq[m_c]) begin
            m_lock = 1;
            m_own  = m_c;
            break;
          end
        end
      end else if (rq[m_own] && rdy) begin
        m_flit  = fl[32*m_own +: 32];
        m_fv    = 1;
        m_stall = 0;
        if (m_flit[31]) begin
          m_lock = 0;
          m_ptr  = m_own;
        end
      end else if (m_stall == 49) begin
        m_lock  = 0;
        m_ptr   = m_own;
        m_to    = 1;
        m_stall = 0;
      end else begin
        m_stall++;
      end
    end
  endtask

  function automatic logic [63:0] model_outs();
    logic [4:0] g;
    logic [2:0] gt;
    g  = m_lock ? (5'b00001 << m_own) : 5'b00000;
    gt = m_lock ? 3'(m_own) : 3'b111;
    return {17'h0, g, gt, m_flit, 1'(m_fv), (m_lock ? 4'h0 : 4'hF), 1'(m_lock), 1'(m_to)};
  endfunction

  function automatic logic [63:0] dut_outs();
    return {17'h0, bus.grant, bus.gate, bus.flit_out, bus.flit_valid, bus.owner, bus.busy, bus.timeout};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    bus.enable = 1'b1; bus.req = '0; bus.out_ready = 1'b0; bus.flit_in = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  int          to_first, to_count, fv_seen;
  logic [4:0]  grant_at_to;
  logic [159:0] rfl;
  logic [31:0]  w;

  initial begin
    tbl[0]  = mk(1'b1, 5'b00001, 1'b1, 2'b11, 5'b00001, 3'd0, 1'b0, 32'h0, 1'b1);
    tbl[1]  = mk(1'b1, 5'b00001, 1'b1, 2'b11, 5'b00000, 3'd7, 1'b1, 32'hC000_0000, 1'b0);
    tbl[2]  = mk(1'b1, 5'b11111, 1'b1, 2'b11, 5'b00010, 3'd1, 1'b0, 32'h0, 1'b1);
    tbl[3]  = mk(1'b1, 5'b11111, 1'b1, 2'b11, 5'b00000, 3'd7, 1'b1, 32'hC000_0001, 1'b0);
    tbl[4]  = mk(1'b1, 5'b11111, 1'b1, 2'b11, 5'b00100, 3'd2, 1'b0, 32'h0, 1'b1);
    tbl[5]  = mk(1'b1, 5'b11111, 1'b1, 2'b11, 5'b00000, 3'd7, 1'b1, 32'hC000_0002, 1'b0);
    tbl[6]  = mk(1'b1, 5'b11111, 1'b1, 2'b11, 5'b01000, 3'd3, 1'b0, 32'h0, 1'b1);
    tbl[7]  = mk(1'b1, 5'b11111, 1'b1, 2'b11, 5'b00000, 3'd7, 1'b1, 32'hC000_0003, 1'b0);
    tbl[8]  = mk(1'b1, 5'b11111, 1'b1, 2'b11, 5'b10000, 3'd4, 1'b0, 32'h0, 1'b1);
    tbl[9]  = mk(1'b1, 5'b11111, 1'b1, 2'b11, 5'b00000, 3'd7, 1'b1, 32'hC000_0004, 1'b0);
    tbl[10] = mk(1'b1, 5'b11111, 1'b1, 2'b11, 5'b00001, 3'd0, 1'b0, 32'h0, 1'b1);
    tbl[11] = mk(1'b1, 5'b11111, 1'b1, 2'b11, 5'b00000, 3'd7, 1'b1, 32'hC000_0000, 1'b0);
    tbl[12] = mk(1'b1, 5'b00010, 1'b1, 2'b01, 5'b00010, 3'd1, 1'b0, 32'h0, 1'b1);
    tbl[13] = mk(1'b1, 5'b00010, 1'b1, 2'b01, 5'b00010, 3'd1, 1'b1, 32'h4000_0001, 1'b1);
    tbl[14] = mk(1'b1, 5'b00010, 1'b0, 2'b00, 5'b00010, 3'd1, 1'b0, 32'h0, 1'b1);
    tbl[15] = mk(1'b0, 5'b00010, 1'b1, 2'b00, 5'b00010, 3'd1, 1'b0, 32'h0, 1'b1);
    tbl[16] = mk(1'b1, 5'b00011, 1'b1, 2'b00, 5'b00010, 3'd1, 1'b1, 32'h0000_0001, 1'b1);
    tbl[17] = mk(1'b1, 5'b00011, 1'b1, 2'b10, 5'b00000, 3'd7, 1'b1, 32'h8000_0001, 1'b0);
    tbl[18] = mk(1'b1, 5'b00011, 1'b1, 2'b11, 5'b00001, 3'd0, 1'b0, 32'h0, 1'b1);
    tbl[19] = mk(1'b0, 5'b00001, 1'b1, 2'b11, 5'b00001, 3'd0, 1'b0, 32'h0, 1'b1);
    tbl[20] = mk(1'b1, 5'b00001, 1'b1, 2'b11, 5'b00000, 3'd7, 1'b1, 32'hC000_0000, 1'b0);
    tbl[21] = mk(1'b1, 5'b00000, 1'b1, 2'b11, 5'b00000, 3'd7, 1'b0, 32'h0, 1'b0);

    // Reset values
    do_reset();
    chk("rst_grant", 64'(bus.grant), 64'h0);
    chk("rst_gate", 64'(bus.gate), 64'h7);
    chk("rst_flit_out", 64'(bus.flit_out), 64'h0);
    chk("rst_flit_valid", 64'(bus.flit_valid), 64'h0);
    chk("rst_owner", 64'(bus.owner), 64'hF);
    chk("rst_busy_timeout", 64'({bus.busy, bus.timeout}), 64'h0);

    // Directed vector table
    for (int i = 0; i < 22; i++) begin
      bus.enable = tbl[i].en; bus.req = tbl[i].rq; bus.out_ready = tbl[i].rdy;
      bus.flit_in = flits_of(tbl[i].ty);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_grant", i), 64'(bus.grant), 64'(tbl[i].g));
      chk($sformatf("vec%0d_gate", i), 64'(bus.gate), 64'(tbl[i].gt));
      chk($sformatf("vec%0d_fv", i), 64'(bus.flit_valid), 64'(tbl[i].fv));
      chk($sformatf("vec%0d_busy_owner", i), 64'({bus.busy, bus.owner}),
          64'({tbl[i].b, (tbl[i].b ? 4'h0 : 4'hF)}));
      chk($sformatf("vec%0d_timeout", i), 64'(bus.timeout), 64'h0);
      if (tbl[i].fv) chk($sformatf("vec%0d_flit", i), 64'(bus.flit_out), 64'(tbl[i].fo));
    end

    // Watchdog: lock on requester 1, link never ready
    bus.enable = 1'b1; bus.req = 5'b00010; bus.out_ready = 1'b0; bus.flit_in = flits_of(2'b01);
    @(posedge clk);
    #1;
    chk("wd_lock_grant", 64'(bus.grant), 64'h02);
    to_first = -1; to_count = 0; fv_seen = 0; grant_at_to = 5'h1F;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (bus.flit_valid) fv_seen++;
      if (bus.timeout) begin
        to_count++;
        if (to_first < 0) begin
          to_first = n;
          grant_at_to = bus.grant;
        end
      end
    end
    chk("wd_first_timeout_edge", 64'(to_first), 64'd50);
    chk("wd_timeout_pulses", 64'(to_count), 64'd1);
    chk("wd_grant_at_timeout", 64'(grant_at_to), 64'h0);
    chk("wd_no_flit_valid", 64'(fv_seen), 64'd0);

    // Async reset while locked, with flit_valid high
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_fv_before", 64'({bus.flit_valid, bus.grant}), 64'({1'b1, 5'b00010}));
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid_grant_gate", 64'({bus.grant, bus.gate}), 64'({5'b00000, 3'b111}));
    chk("rstmid_fv_flit", 64'({bus.flit_valid, bus.flit_out}), 64'h0);
    chk("rstmid_owner_busy", 64'({bus.owner, bus.busy, bus.timeout}), 64'({4'hF, 2'b00}));
    @(negedge clk);
    reset = 1'b1;
    bus.req = 5'b11111; bus.flit_in = flits_of(2'b11);
    @(posedge clk);
    #1;
    chk("rstmid_first_grant", 64'(bus.grant), 64'h01);

    // Random traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.req = 5'($urandom_range(0, 31));
      bus.out_ready = ((c % 300) < 220) ? ($urandom_range(0, 3) != 0) : 1'b0;
      for (int i = 0; i < 5; i++) begin
        w = $urandom;
        rfl[32*i +: 32] = w;
      end
      bus.flit_in = rfl;
      model_step(bus.enable, bus.req, bus.out_ready, rfl);
      @(posedge clk);
      #1;
      chk($sformatf("rand%0d", c), dut_outs(), model_outs());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
